// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, word geometry
// and the instruction-address stride.
package prog_loader_pkg;

  // State encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_HI = 3'd1;
  localparam logic [2:0] ST_CNT_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHK    = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CNT_HI = ST_CNT_HI,
    S_CNT_LO = ST_CNT_LO,
    S_DATA   = ST_DATA,
    S_WRITE  = ST_WRITE,
    S_CHK    = ST_CHK,
    S_DONE   = ST_DONE
  } state_t;

  // Bytes per instruction word and byte-address step between words
  localparam int          WORD_BYTES  = 4;
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// master = byte producer, slave = the loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader_shift.sv
// Big-endian word assembler. Holds the first three bytes of a word; the
// fourth byte is combined directly so the complete word is available on the
// same edge that accepts the last byte.
module prog_loader_shift
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_full
);

  localparam int CW     = $clog2(WORD_BYTES);
  localparam int HEAD_W = 8 * (WORD_BYTES - 1);

  logic [HEAD_W-1:0] head_reg;
  logic [CW-1:0]     cnt_reg;

  // Shift bytes in MSB-first; the byte counter wraps back to 0 after a word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg <= '0;
      cnt_reg  <= '0;
    end else if (clear) begin
      cnt_reg  <= '0;
    end else if (shift_en) begin
      head_reg <= {head_reg[HEAD_W-9:0], byte_in};
      cnt_reg  <= cnt_reg + CW'(1);
    end
  end

  assign word_next = {head_reg, byte_in};
  assign word_full = shift_en && (cnt_reg == CW'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a 16-bit big-endian word count followed by
// big-endian instruction words on a byte stream and writes them into CPU
// instruction memory while holding the CPU in debug/halt.
// Optional build macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte after the last data word.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  prog_loader_if.slave  stream,
  output logic          prog_en,
  output logic [31:0]   inst_addr,
  output logic [31:0]   prog_instruction,
  output logic          debug,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t         state;
  logic [7:0]     count_hi_reg;
  logic [CNT_W-1:0] remain_reg;
  logic [31:0]    inst_addr_reg;
  logic [31:0]    prog_instruction_reg;
  logic           prog_en_reg;
  logic           debug_reg;
  logic           done_reg;
  logic           err_reg;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]     csum_reg;
`endif

  logic           xfer;
  logic [CNT_W-1:0] hdr_count;
  logic [31:0]    word_next;
  logic           word_full;

  assign xfer      = stream.in_valid && stream.in_ready;
  assign hdr_count = CNT_W'({count_hi_reg, stream.in_data});

  // Byte acceptance is a pure decode of the registered state
  assign stream.in_ready = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                           (state == S_DATA)   || (state == S_CHK);

  prog_loader_shift u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     ((state == S_IDLE) && start),
    .shift_en  (xfer && (state == S_DATA)),
    .byte_in   (stream.in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // Load sequencer with registered strobes and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      count_hi_reg         <= '0;
      remain_reg           <= '0;
      inst_addr_reg        <= BASE_ADDR;
      prog_instruction_reg <= '0;
      prog_en_reg          <= 1'b0;
      debug_reg            <= 1'b0;
      done_reg             <= 1'b0;
      err_reg              <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_reg             <= '0;
`endif
    end else begin
      prog_en_reg <= 1'b0;
      done_reg    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err_reg       <= 1'b0;
            debug_reg     <= 1'b1;
            inst_addr_reg <= BASE_ADDR;
            count_hi_reg  <= '0;
            remain_reg    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_reg      <= '0;
`endif
            state         <= S_CNT_HI;
          end
        end
        S_CNT_HI: begin
          if (xfer) begin
            count_hi_reg <= stream.in_data;
            state        <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (xfer) begin
            remain_reg <= hdr_count;
            if (hdr_count == '0) begin
              done_reg <= 1'b1;
              state    <= S_DONE;
            end else if (32'(hdr_count) > MAX_W) begin
              err_reg  <= 1'b1;
              done_reg <= 1'b1;
              state    <= S_DONE;
            end else begin
              state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_reg <= csum_reg ^ stream.in_data;
`endif
            if (word_full) begin
              prog_instruction_reg <= word_next;
              prog_en_reg          <= 1'b1;
              state                <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          inst_addr_reg <= inst_addr_reg + ADDR_STRIDE;
          remain_reg    <= remain_reg - CNT_W'(1);
          if (remain_reg == CNT_W'(1)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state    <= S_CHK;
`else
            done_reg <= 1'b1;
            state    <= S_DONE;
`endif
          end else begin
            state <= S_DATA;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            err_reg  <= err_reg | (stream.in_data != csum_reg);
            done_reg <= 1'b1;
            state    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          debug_reg <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign prog_en          = prog_en_reg;
  assign inst_addr        = inst_addr_reg;
  assign prog_instruction = prog_instruction_reg;
  assign debug            = debug_reg;
  assign busy             = (state != S_IDLE);
  assign done             = done_reg;
  assign err              = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader. Expected writes, error flag
// and handshake timing come from a behavioural model of the load protocol.
module tb_prog_loader;

  localparam logic [31:0] BASE      = 32'd0;
  localparam int          MAX_WORDS = 1024;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        prog_en;
  logic [31:0] inst_addr;
  logic [31:0] prog_instruction;
  logic        debug;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader_if bus ();

  prog_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAX_WORDS),
    .CNT_W     (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .stream           (bus.slave),
    .prog_en          (prog_en),
    .inst_addr        (inst_addr),
    .prog_instruction (prog_instruction),
    .debug            (debug),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] wq[$];
  int          done_cnt = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: records every write strobe and counts done pulses
  always @(posedge clk) begin
    #1;
    if (prog_en === 1'b1) begin
      got_addr.push_back(inst_addr);
      got_data.push_back(prog_instruction);
      chk("write_while_ready", {31'b0, bus.in_ready}, 32'd0);
      $display("write addr=%h data=%h", inst_addr, prog_instruction);
    end
    if (done === 1'b1) done_cnt++;
  end

  // Present one byte after a random idle gap; returns on the negedge after the transfer
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int n;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $error("FAIL byte_timeout: got in_ready=%b expected 1 within 200 cycles", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom);
  endtask

  // One complete load of wq[0..count-1], checked against the protocol model
  task automatic run_load(input int count, input int gap, input bit bad_csum, input bit start_mid);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] c16;
    logic [31:0] w;
    bit          over;
    bit          exp_err;
    int          n;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    over = (count > MAX_WORDS);
    c16  = 16'(count);
    cs   = 8'h00;
    do_start();
    chk("start_busy",  {31'b0, busy},  32'd1);
    chk("start_debug", {31'b0, debug}, 32'd1);
    chk("start_err",   {31'b0, err},   32'd0);
    send_byte(c16[15:8], gap);
    send_byte(c16[7:0], gap);
    if (count == 0 || over) begin
      chk("hdr_done", {31'b0, done}, 32'd1);
      exp_err = over;
      n = 0;
    end else begin
      if (start_mid) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int i = 0; i < count; i++) begin
        w = wq[i];
        for (int k = 3; k >= 0; k--) begin
          b = w[8*k +: 8];
          send_byte(b, gap);
          cs = cs ^ b;
        end
        chk("lat_prog_en", {31'b0, prog_en}, 32'd1);
        chk("lat_addr", inst_addr, BASE + 32'(4 * i));
        chk("lat_data", prog_instruction, w);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gap);
      exp_err = bad_csum;
`else
      @(negedge clk);
      exp_err = 1'b0;
      if (bad_csum) $display("note: checksum byte not part of this build");
`endif
      chk("end_done", {31'b0, done}, 32'd1);
      n = count;
    end
    chk("done_debug_hi", {31'b0, debug}, 32'd1);
    @(negedge clk);
    chk("done_pulse_end", {31'b0, done},  32'd0);
    chk("debug_low",      {31'b0, debug}, 32'd0);
    chk("busy_low",       {31'b0, busy},  32'd0);
    chk("err_flag",       {31'b0, err},   {31'b0, exp_err});
    chk("done_count",     32'(done_cnt),  32'd1);
    chk("write_count",    32'(got_addr.size()), 32'(n));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      chk("wr_addr", got_addr[i], BASE + 32'(4 * i));
      chk("wr_data", got_data[i], wq[i]);
    end
    if (n > 0) chk("hold_instr", prog_instruction, wq[n-1]);
    $display("load count=%0d gap=%0d writes=%0d err=%b", count, gap, got_addr.size(), err);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_prog_en", {31'b0, prog_en},  32'd0);
    chk("rst_ready",   {31'b0, bus.in_ready}, 32'd0);
    chk("rst_debug",   {31'b0, debug},    32'd0);
    chk("rst_busy",    {31'b0, busy},     32'd0);
    chk("rst_done",    {31'b0, done},     32'd0);
    chk("rst_err",     {31'b0, err},      32'd0);
    chk("rst_addr",    inst_addr,         BASE);
    chk("rst_instr",   prog_instruction,  32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ADDI program, back-to-back bytes
    wq.delete();
    wq.push_back(32'h2008000A);
    wq.push_back(32'h20090014);
    wq.push_back(32'h200A001E);
    wq.push_back(32'h200B0028);
    run_load(4, 0, 1'b0, 1'b0);

    // Same program with random stalls between bytes
    run_load(4, 5, 1'b0, 1'b0);

    // Random programs with random stalls; one with a start pulse mid-load
    for (int t = 0; t < 3; t++) begin
      nw = int'($urandom_range(6, 1));
      fill_rand(nw);
      run_load(nw, 5, 1'b0, (t == 1));
    end

    // Zero count
    wq.delete();
    run_load(0, 0, 1'b0, 1'b0);

    // Over-limit header, then a good load clears err
    run_load(MAX_WORDS + 1, 0, 1'b0, 1'b0);
    fill_rand(2);
    run_load(2, 2, 1'b0, 1'b0);

    // Exactly the maximum word count is accepted
    fill_rand(MAX_WORDS);
    run_load(MAX_WORDS, 0, 1'b0, 1'b0);

    // Reset in the middle of the first word
    fill_rand(2);
    got_addr.delete();
    got_data.delete();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(wq[0][31:24], 0);
    send_byte(wq[0][23:16], 0);
    reset_n = 1'b0;
    #1;
    chk("arst_prog_en", {31'b0, prog_en},  32'd0);
    chk("arst_ready",   {31'b0, bus.in_ready}, 32'd0);
    chk("arst_debug",   {31'b0, debug},    32'd0);
    chk("arst_busy",    {31'b0, busy},     32'd0);
    chk("arst_err",     {31'b0, err},      32'd0);
    chk("arst_addr",    inst_addr,         BASE);
    chk("arst_instr",   prog_instruction,  32'd0);
    repeat (3) @(negedge clk);
    chk("arst_no_write", 32'(got_addr.size()), 32'd0);
    $display("reset mid-word writes=%0d", got_addr.size());
    reset_n = 1'b1;
    @(negedge clk);
    run_load(2, 3, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum: DE^AD^BE^EF = 22
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b1, 1'b0);
    fill_rand(3);
    run_load(3, 4, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
